// File: rtl/intt_output_collector.sv
// Collects one INTT output frame (CORES pairs-of-pairs per beat) and streams it out in natural index order.
// Optional write-mask duplicate detection is enabled with `define INTT_COLLECT_DUP_CHECK_EN.
module intt_output_collector #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 12,
    parameter int COEFF_WIDTH    = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*COEFF_WIDTH-1:0]   in [0:(1<<LOG_CORE_COUNT)-1][0:1],
    input  logic [8:0]                 address_in,
    input  logic                       in_valid,
    output logic                       busy,
    output logic [COEFF_WIDTH-1:0]     out_data,
    output logic [LOG_N-1:0]           out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       err_overflow,
`ifdef INTT_COLLECT_DUP_CHECK_EN
    output logic                       err_dup,
`endif
    output logic                       err_addr
);

    localparam int CORES     = 1 << LOG_CORE_COUNT;
    localparam int N         = 1 << LOG_N;
    localparam int LOG_BEATS = LOG_N - LOG_CORE_COUNT - 2;
    localparam int BEATS     = 1 << LOG_BEATS;
    localparam int RW        = 4 * COEFF_WIDTH;
    localparam logic [LOG_BEATS:0] LAST_BEAT = (LOG_BEATS + 1)'(BEATS - 1);
    localparam logic [LOG_N-1:0]   LAST_IDX  = LOG_N'(N - 1);
    localparam logic [8:0]         BEATS_W   = 9'(BEATS);

    typedef enum logic [0:0] {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [LOG_BEATS:0]     beat_cnt_q, beat_cnt_d;
    logic [LOG_N-1:0]       rd_idx_q, rd_idx_d;
    logic                   rd_done_q, rd_done_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [LOG_N-1:0]       s1_idx_q, s1_idx_d;
    logic [RW-1:0]          s1_row_q, s1_row_d;
    logic                   out_valid_q, out_valid_d;
    logic [COEFF_WIDTH-1:0] out_data_q, out_data_d;
    logic [LOG_N-1:0]       out_index_q, out_index_d;
    logic                   out_last_q, out_last_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_overflow_q, err_overflow_d;
    logic                   err_addr_q, err_addr_d;
`ifdef INTT_COLLECT_DUP_CHECK_EN
    logic [BEATS-1:0]       mask_q, mask_d;
    logic [BEATS-1:0]       mask_base_s;
    logic                   err_dup_q, err_dup_d;
    logic                   dup_s;
`endif

    logic [RW-1:0]              mem_q [0:CORES-1][0:BEATS-1];
    logic                       addr_ok_s;
    logic                       drain_finish_s;
    logic                       fill_window_s;
    logic                       accept_s;
    logic                       advance_s;
    logic                       go_drain_s;
    logic                       count_s;
    logic [LOG_BEATS-1:0]       wr_addr_s;
    logic [LOG_CORE_COUNT-1:0]  rd_k_s;
    logic [LOG_BEATS-1:0]       rd_a_s;

    // A beat arriving on the cycle the last coefficient leaves already belongs to the next frame.
    assign addr_ok_s      = (address_in < BEATS_W);
    assign drain_finish_s = (state_q == DRAIN) && out_valid_q && out_ready && out_last_q;
    assign fill_window_s  = (state_q == FILL) || drain_finish_s;
    assign accept_s       = in_valid && addr_ok_s && fill_window_s;
    assign advance_s      = !out_valid_q || out_ready;
    assign wr_addr_s      = address_in[LOG_BEATS-1:0];
    assign rd_k_s         = rd_idx_q[LOG_N-1 -: LOG_CORE_COUNT];
    assign rd_a_s         = rd_idx_q[LOG_N-LOG_CORE_COUNT-1:2];

    // Frame storage: one row per core per beat address, never reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int k = 0; k < CORES; k++) begin
                mem_q[k][wr_addr_s] <= {in[k][1], in[k][0]};
            end
        end
    end

    // Next-state logic for fill counting, read pipeline and status flags.
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        rd_idx_d       = rd_idx_q;
        rd_done_d      = rd_done_q;
        s1_valid_d     = s1_valid_q;
        s1_idx_d       = s1_idx_q;
        s1_row_d       = s1_row_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_index_d    = out_index_q;
        out_last_d     = out_last_q;
        frame_done_d   = 1'b0;
        err_overflow_d = err_overflow_q;
        err_addr_d     = err_addr_q;
        go_drain_s     = 1'b0;
        count_s        = 1'b0;
`ifdef INTT_COLLECT_DUP_CHECK_EN
        mask_d         = mask_q;
        err_dup_d      = err_dup_q;
        dup_s          = 1'b0;
        mask_base_s    = (state_q == FILL) ? mask_q : {BEATS{1'b0}};
`endif
        case (state_q)
            FILL: begin
                s1_valid_d = 1'b0;
            end
            DRAIN: begin
                if (in_valid && !drain_finish_s) begin
                    err_overflow_d = 1'b1;
                end else begin
                    err_overflow_d = err_overflow_q;
                end
                // Whole two-stage pipeline stalls together, so nothing is skipped or repeated.
                if (advance_s) begin
                    out_valid_d = s1_valid_q;
                    out_data_d  = s1_row_q[s1_idx_q[1:0]*COEFF_WIDTH +: COEFF_WIDTH];
                    out_index_d = s1_idx_q;
                    out_last_d  = s1_valid_q && (s1_idx_q == LAST_IDX);
                    if (!rd_done_q) begin
                        s1_valid_d = 1'b1;
                        s1_idx_d   = rd_idx_q;
                        s1_row_d   = mem_q[rd_k_s][rd_a_s];
                        rd_idx_d   = rd_idx_q + LOG_N'(1);
                        rd_done_d  = (rd_idx_q == LAST_IDX);
                    end else begin
                        s1_valid_d = 1'b0;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
                if (drain_finish_s) begin
                    state_d      = FILL;
                    frame_done_d = 1'b1;
                    rd_idx_d     = {LOG_N{1'b0}};
                    rd_done_d    = 1'b0;
`ifdef INTT_COLLECT_DUP_CHECK_EN
                    mask_d       = {BEATS{1'b0}};
`endif
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (fill_window_s && in_valid) begin
            if (!addr_ok_s) begin
                err_addr_d = 1'b1;
            end else begin
`ifdef INTT_COLLECT_DUP_CHECK_EN
                dup_s      = mask_base_s[wr_addr_s];
                mask_d     = mask_base_s | ({{(BEATS-1){1'b0}}, 1'b1} << wr_addr_s);
                err_dup_d  = err_dup_q | dup_s;
                count_s    = !dup_s;
                go_drain_s = &mask_d;
`else
                count_s    = 1'b1;
                go_drain_s = (beat_cnt_q == LAST_BEAT);
`endif
            end
        end else begin
            err_addr_d = err_addr_q;
        end

        if (go_drain_s) begin
            state_d    = DRAIN;
            beat_cnt_d = {(LOG_BEATS+1){1'b0}};
        end else if (count_s) begin
            beat_cnt_d = beat_cnt_q + (LOG_BEATS + 1)'(1);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FILL;
            beat_cnt_q     <= {(LOG_BEATS+1){1'b0}};
            rd_idx_q       <= {LOG_N{1'b0}};
            rd_done_q      <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_idx_q       <= {LOG_N{1'b0}};
            s1_row_q       <= {RW{1'b0}};
            out_valid_q    <= 1'b0;
            out_data_q     <= {COEFF_WIDTH{1'b0}};
            out_index_q    <= {LOG_N{1'b0}};
            out_last_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            err_addr_q     <= 1'b0;
`ifdef INTT_COLLECT_DUP_CHECK_EN
            mask_q         <= {BEATS{1'b0}};
            err_dup_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            rd_idx_q       <= rd_idx_d;
            rd_done_q      <= rd_done_d;
            s1_valid_q     <= s1_valid_d;
            s1_idx_q       <= s1_idx_d;
            s1_row_q       <= s1_row_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_index_q    <= out_index_d;
            out_last_q     <= out_last_d;
            frame_done_q   <= frame_done_d;
            err_overflow_q <= err_overflow_d;
            err_addr_q     <= err_addr_d;
`ifdef INTT_COLLECT_DUP_CHECK_EN
            mask_q         <= mask_d;
            err_dup_q      <= err_dup_d;
`endif
        end
    end

    assign busy         = (state_q == DRAIN);
    assign out_data     = out_data_q;
    assign out_index    = out_index_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign frame_done   = frame_done_q;
    assign err_overflow = err_overflow_q;
    assign err_addr     = err_addr_q;
`ifdef INTT_COLLECT_DUP_CHECK_EN
    assign err_dup      = err_dup_q;
`endif

endmodule

// File: tb/tb_intt_output_collector.sv
// Directed bench for intt_output_collector: a bench-side coefficient model feeds an expected-stream queue.
module tb_intt_output_collector;

    localparam int CORES = 32;
    localparam int N     = 4096;
    localparam int BEATS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [59:0] din [0:CORES-1][0:1];
    logic [8:0]  address_in;
    logic        in_valid;
    logic        busy;
    logic [29:0] out_data;
    logic [11:0] out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        frame_done;
    logic        err_overflow;
    logic        err_addr;
`ifdef INTT_COLLECT_DUP_CHECK_EN
    logic        err_dup;
`endif

    typedef struct {
        int          idx;
        logic [29:0] data;
    } exp_t;

    exp_t        exp_q [$];
    logic [29:0] model [0:N-1];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          acc;

    always #5 clk = ~clk;

    intt_output_collector dut (
        .clk          (clk),
        .rst          (rst),
        .in           (din),
        .address_in   (address_in),
        .in_valid     (in_valid),
        .busy         (busy),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .frame_done   (frame_done),
        .err_overflow (err_overflow),
`ifdef INTT_COLLECT_DUP_CHECK_EN
        .err_dup      (err_dup),
`endif
        .err_addr     (err_addr)
    );

    function automatic logic [29:0] coef(input int idx, input int salt);
        coef = 30'(salt * 8192 + idx);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            if (n_fail <= 20) $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // upd=0 marks a beat the DUT must drop (sent while draining)
    task automatic beat(input int addr, input int salt, input bit upd);
        int base;
        for (int k = 0; k < CORES; k++) begin
            base = k * (N / CORES) + 4 * (addr % BEATS);
            din[k][0] = {coef(base + 1, salt), coef(base, salt)};
            din[k][1] = {coef(base + 3, salt), coef(base + 2, salt)};
            if (upd && addr < BEATS) begin
                for (int j = 0; j < 4; j++) model[base + j] = coef(base + j, salt);
            end
        end
        address_in = 9'(addr);
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic push_frame();
        for (int i = 0; i < N; i++) exp_q.push_back('{idx: i, data: model[i]});
    endtask

    task automatic fill(input int salt, input bit reverse);
        for (int b = 0; b < BEATS; b++) begin
            beat(reverse ? (BEATS - 1 - b) : b, salt, 1'b1);
            if (b == BEATS - 2) check("busy_before_last_beat", busy, 1'b0);
            if (b == BEATS - 1) check("busy_after_last_beat", busy, 1'b1);
        end
        push_frame();
    endtask

    // mode 0: out_ready held high; mode 1: random 50% out_ready
    task automatic drain(input int mode, input int stop_after, output int n_acc);
        int budget;
        budget = 30000;
        n_acc  = 0;
        while (n_acc < stop_after && budget > 0) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", out_valid, 1'b0);
                end else begin
                    check("out_index", out_index, exp_q[0].idx);
                    check("out_data", out_data, exp_q[0].data);
                    check("out_last", out_last, exp_q[0].idx == N - 1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
            end
            step();
            budget--;
        end
        out_ready = 1'b1;
        if (budget == 0) check("drain_timeout", n_acc, stop_after);
    endtask

    task automatic end_check();
        check("end_out_valid", out_valid, 1'b0);
        check("end_frame_done", frame_done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_queue_empty", exp_q.size(), 0);
        step();
        check("frame_done_pulse", frame_done, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < CORES; k++) begin
            din[k][0] = 60'd0;
            din[k][1] = 60'd0;
        end
        for (int i = 0; i < N; i++) model[i] = 30'd0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        address_in = 9'd0;
        out_ready  = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_err_addr", err_addr, 1'b0);
        check("rst_out_data", out_data, 30'd0);
        check("rst_out_index", out_index, 12'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // in-order fill, c = index, with first-valid latency
        fill(0, 1'b0);
        check("lat_edge0_valid", out_valid, 1'b0);
        step();
        check("lat_edge1_valid", out_valid, 1'b0);
        step();
        check("lat_edge2_valid", out_valid, 1'b1);
        drain(0, N, acc);
        end_check();

        // reverse-order fill gives the identical stream
        fill(0, 1'b1);
        check("model_idx406", model[406], 30'd406);
        drain(0, N, acc);
        end_check();

        // random backpressure
        fill(3, 1'b0);
        drain(1, N, acc);
        check("random_acc_count", acc, N);
        end_check();

        // bad address during fill, overflow during drain
        for (int b = 0; b < 16; b++) beat(b, 4, 1'b1);
        beat(40, 4, 1'b1);
        check("err_addr_set", err_addr, 1'b1);
        check("err_addr_no_overflow", err_overflow, 1'b0);
        for (int b = 16; b < BEATS; b++) begin
            beat(b, 4, 1'b1);
            if (b == BEATS - 2) check("busy_33rd_pending", busy, 1'b0);
        end
        check("busy_after_33", busy, 1'b1);
        push_frame();
        beat(5, 9, 1'b0);
        check("err_overflow_set", err_overflow, 1'b1);
        drain(1, N, acc);
        end_check();
        check("err_overflow_sticky", err_overflow, 1'b1);
        check("err_addr_sticky", err_addr, 1'b1);

        // reset mid-drain, then a fresh frame from index 0
        fill(5, 1'b0);
        drain(0, 2000, acc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err_overflow", err_overflow, 1'b0);
        check("midrst_err_addr", err_addr, 1'b0);
        check("midrst_out_index", out_index, 12'd0);
        exp_q.delete();
        fill(6, 1'b1);
        drain(0, N, acc);
        end_check();

`ifdef INTT_COLLECT_DUP_CHECK_EN
        beat(7, 7, 1'b1);
        check("dup_first_clear", err_dup, 1'b0);
        beat(7, 8, 1'b1);
        check("dup_flag", err_dup, 1'b1);
        for (int b = 0; b < BEATS; b++) begin
            if (b != 7) begin
                beat(b, 8, 1'b1);
                if (b == BEATS - 2) check("dup_busy_at_32", busy, 1'b0);
            end
        end
        check("dup_busy_at_33", busy, 1'b1);
        check("dup_idx28_model", model[28], coef(28, 8));
        push_frame();
        drain(0, N, acc);
        end_check();
        check("dup_sticky", err_dup, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intt_output_collector.md
Name: intt_output_collector

Overview:
- Receiver on the final-output side of the INTT router.
- Accepts each final-iteration beat: two 60-bit coefficient pairs per core plus one shared word address.
- Buffers one full polynomial frame of N coefficients, then streams them out one per cycle in natural index order over a valid/ready interface.
- Sits between the INTT router's out/address_out outputs and the host/DMA result path.

Parameters:
- LOG_CORE_COUNT, 5, log2 of core count; CORES = 1 << LOG_CORE_COUNT.
- LOG_N, 12, log2 of polynomial length N.
- COEFF_WIDTH, 30, coefficient width in bits; pair width = 2*COEFF_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  [2*COEFF_WIDTH-1:0] x [CORES][2]  per-core pairs; in[k][0]={c1,c0}, in[k][1]={c3,c2}.
- address_in  input  9  word address shared by all cores for this beat.
- in_valid  input  1  beat present on in/address_in this cycle.
- busy  output  1  high while draining; input beats are not accepted.
- out_data  output  COEFF_WIDTH  streamed coefficient.
- out_index  output  LOG_N  natural index of out_data.
- out_valid  output  1  out_data/out_index valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_last  output  1  high with index N-1.
- frame_done  output  1  one-cycle pulse after the last coefficient is accepted.
- err_overflow  output  1  sticky: in_valid seen while busy.
- err_addr  output  1  sticky: in_valid with address_in >= BEATS.

Behaviour:
- Index mapping (decided): BEATS = N/(4*CORES), which is 32 by default. Coefficient cj (j=0..3) of core k at address a has index = k*(N/CORES) + 4*a + j.
- Storage: CORES x BEATS words of 4*COEFF_WIDTH bits. Each accepted beat writes the row address_in for all cores in one cycle.
- States:
  - FILL (reset state): busy=0.
    - Accept a beat when in_valid=1 and address_in < BEATS, then increment beat_cnt.
    - If in_valid=1 and address_in >= BEATS: drop the beat, set err_addr, do not count it.
    - On the accepted beat that makes beat_cnt == BEATS: go to DRAIN next cycle and reset beat_cnt to 0.
  - DRAIN: busy=1.
    - Read counter rd_idx runs 0..N-1 and decodes to k = rd_idx[LOG_N-1:LOG_N-LOG_CORE_COUNT], a = rd_idx[LOG_N-LOG_CORE_COUNT-1:2], j = rd_idx[1:0].
    - Registered read with 1-cycle latency: out_valid first rises 2 cycles after the clock edge that captured the final beat.
    - While out_valid && !out_ready: out_data, out_index and out_last hold stable. No index is skipped or repeated.
    - Throughput is 1 coefficient/cycle when out_ready is held high.
    - Any in_valid during DRAIN sets err_overflow; the beat is dropped and memory is unchanged.
    - On acceptance of index N-1: out_valid=0 and frame_done=1 next cycle, return to FILL.
- A beat on the same cycle as the DRAIN->FILL transition is accepted as beat 1 of the next frame.
- Duplicate addresses within a frame count as separate beats, and the later write wins. Hazard is checked only with the optional feature.
- Reset: synchronous, takes effect mid-frame or mid-drain.
  - State=FILL, beat_cnt=0, rd_idx=0.
  - out_valid=0, out_last=0, frame_done=0, busy=0, err_overflow=0, err_addr=0, out_data=0, out_index=0.
  - Memory contents are not cleared.

Optional Feature:
- Macro: INTT_COLLECT_DUP_CHECK_EN.
- Defined:
  - Adds a BEATS-bit written mask, cleared on rst and on entry to FILL.
  - An accepted beat whose address bit is already set raises sticky output err_dup. The beat still writes but is not counted.
  - DRAIN starts only when all mask bits are set.
- Undefined: err_dup port is absent, and the beat counter alone triggers DRAIN.

Test Plan:
- Fill addresses 0..31 in order with c = index value, out_ready=1:
  - out_index 0..4095 consecutively with out_data == out_index.
  - out_last at 4095, frame_done one cycle later.
  - First out_valid 2 cycles after the final beat.
- Fill addresses in reverse order 31..0:
  - Identical stream to the previous test; core 3, address 5, c2 appears at index 406.
- Toggle out_ready with a random 50% pattern during drain:
  - No index is dropped or duplicated.
  - out_data stays stable across stalls.
  - 4096 acceptances, then frame_done.
- in_valid during DRAIN, and address_in=40 during FILL:
  - err_overflow=1 and err_addr=1 (sticky).
  - Stream contents are unchanged; a beat with address 40 is not counted (33 beats incl. one at 40 are needed to reach DRAIN).
- Assert rst after 2000 coefficients are drained:
  - Next cycle out_valid=0, busy=0, errors cleared.
  - A new 32-beat frame streams from index 0.
- With INTT_COLLECT_DUP_CHECK_EN: write address 7 twice, then the remaining 31 addresses:
  - err_dup=1.
  - DRAIN starts only after the 33rd beat.
  - Index 28..31 carry the second write's data.
